// File: rtl/qrd_pkg.sv
// Shared definitions for the QRD-RLS array datapath: default geometry and
// small elaboration-time helpers used by the skew, array and deskew blocks.
package qrd_pkg;

  localparam int QRD_N           = 5;
  localparam int QRD_DATA_LENGTH = 8;

  // Low bit of lane k in a packed multi-lane word.
  function automatic int lane_lo(input int k, input int width);
    return k * width;
  endfunction

  // Frame counter width; never narrower than one bit, even for FRAME_LEN=1.
  function automatic int frame_cnt_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/qrd_deskew_lane_delay.sv
// Per-lane delay line carrying {valid, data}; DEPTH register stages with
// async active-low reset, or a plain wire-through when DEPTH is 0.
module lane_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/qrd_deskew.sv
// Output deskew for the QRD-RLS systolic array: realigns the row-staggered
// lanes into one word per sample, tags frame ends and flags misalignment.
module qrd_deskew
  import qrd_pkg::*;
#(
  parameter int N           = QRD_N,
  parameter int DATA_LENGTH = QRD_DATA_LENGTH,
  parameter int FRAME_LEN   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N*DATA_LENGTH-1:0] din,
  input  logic [N-1:0]             din_valid,
  output logic [N*DATA_LENGTH-1:0] dout,
  output logic                     dout_valid,
  output logic                     dout_last,
  output logic                     align_err
);

  localparam int            CW       = frame_cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [N*DATA_LENGTH-1:0] data_al;
  logic [N-1:0]             v;

  // Lane k lags lane 0 by k cycles, so it needs N-1-k stages to catch up.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DATA_LENGTH:0] lane_out;

    lane_delay #(
      .DEPTH(N - 1 - k),
      .WIDTH(DATA_LENGTH + 1)
    ) u_delay (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_i   ({din_valid[k], din[lane_lo(k, DATA_LENGTH) +: DATA_LENGTH]}),
      .q_o   (lane_out)
    );

    assign v[k] = lane_out[DATA_LENGTH];
    assign data_al[lane_lo(k, DATA_LENGTH) +: DATA_LENGTH] = lane_out[DATA_LENGTH-1:0];
  end

  logic                     all_v;
  logic                     any_v;
  logic [N*DATA_LENGTH-1:0] dout_q, dout_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     err_q, err_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  assign all_v = &v;
  assign any_v = |v;

  always_comb begin
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    valid_d = all_v;
    last_d  = 1'b0;
    err_d   = err_q | (any_v & ~all_v);
    if (all_v) begin
      dout_d = data_al;
      last_d = (cnt_q == LAST_IDX);
      cnt_d  = last_d ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign align_err  = err_q;

endmodule

// File: tb/tb_qrd_deskew.sv
// Directed bench for qrd_deskew: default 5-lane instance plus a 1-lane,
// FRAME_LEN=1 instance, checked with immediate assertions.
module tb_qrd_deskew;

  localparam int N  = 5;
  localparam int DL = 8;
  localparam int FL = 5;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*DL-1:0] din   = '0;
  logic [N-1:0]    din_valid = '0;
  logic [N*DL-1:0] dout;
  logic            dout_valid, dout_last, align_err;

  logic [DL-1:0]   din1 = '0;
  logic            din_valid1 = 1'b0;
  logic [DL-1:0]   dout1;
  logic            dout_valid1, dout_last1, align_err1;

  int              n_vec = 0;
  int              n_err = 0;
  int              frame_pos = 0;
  logic [N*DL-1:0] exp_dout = '0;
  logic            exp_err = 1'b0;

  always #5 clk = ~clk;

  qrd_deskew #(.N(N), .DATA_LENGTH(DL), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .align_err(align_err)
  );

  qrd_deskew #(.N(1), .DATA_LENGTH(DL), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(din_valid1),
    .dout(dout1), .dout_valid(dout_valid1), .dout_last(dout_last1), .align_err(align_err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic exp_v, input logic exp_l);
    chk({tag, "/valid"}, 64'(dout_valid), 64'(exp_v));
    chk({tag, "/last"},  64'(dout_last),  64'(exp_l));
    chk({tag, "/dout"},  64'(dout),       64'(exp_dout));
    chk({tag, "/err"},   64'(align_err),  64'(exp_err));
  endtask

  function automatic logic [7:0] samp(input logic [7:0] base, input int s, input int k);
    return 8'(int'(base) + 16 * s + k);
  endfunction

  function automatic logic [N*DL-1:0] pack(input logic [7:0] base, input int s);
    logic [N*DL-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[k*DL +: DL] = samp(base, s, k);
    return w;
  endfunction

  // m staggered samples starting at cycle 0; returns early after stop_after beats.
  task automatic stream(input string tag, input int m, input logic [7:0] base, input int stop_after);
    int beats;
    int s;
    logic exp_l;
    beats = 0;
    for (int c = 0; c < m + N + 1; c++) begin
      for (int k = 0; k < N; k++) begin
        if (c - k >= 0 && c - k < m) begin
          din_valid[k]    = 1'b1;
          din[k*DL +: DL] = samp(base, c - k, k);
        end else begin
          din_valid[k]    = 1'b0;
          din[k*DL +: DL] = 8'($urandom);
        end
      end
      tick();
      s = c - (N - 1);
      if (s >= 0 && s < m) begin
        exp_dout  = pack(base, s);
        exp_l     = (frame_pos == FL - 1);
        frame_pos = (frame_pos + 1) % FL;
        chk_outs(tag, 1'b1, exp_l);
        beats++;
        if (beats == stop_after) return;
      end else begin
        chk_outs(tag, 1'b0, 1'b0);
      end
    end
    din_valid = '0;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = '0;
    din1       = '0;
    din_valid1 = 1'b0;
    exp_dout   = '0;
    exp_err    = 1'b0;
    frame_pos  = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk_outs("por", 1'b0, 1'b0);
    chk("por/dout1", 64'(dout1), 64'h0);
    chk("por/valid1", 64'(dout_valid1), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Ideal stagger, single sample.
    stream("ideal", 1, 8'h10, -1);
    chk("ideal_word", 64'(exp_dout), 64'h14_13_12_11_10);

    // Ten back-to-back samples: last on beats 5 and 10.
    apply_reset();
    stream("frames", 10, 8'h20, -1);

    // Lane 3 one cycle late.
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < N; k++) begin
        din_valid[k]    = (c == ((k == 3) ? 4 : k));
        din[k*DL +: DL] = 8'h55;
      end
      tick();
      if (c >= 4) exp_err = 1'b1;
      chk_outs("misalign", 1'b0, 1'b0);
    end
    din_valid = '0;

    // Counter must be untouched by the misaligned sample.
    stream("post_err", 5, 8'h40, -1);

    // Idle hold with random lane data.
    for (int i = 0; i < 20; i++) begin
      din_valid = '0;
      din = {8'($urandom), 32'($urandom)};
      tick();
      chk_outs("idle", 1'b0, 1'b0);
    end

    // Reset mid-frame, asserted between edges.
    stream("pre_rst", 5, 8'h60, 3);
    #2;
    rst_n     = 1'b0;
    din       = '0;
    din_valid = '0;
    exp_dout  = '0;
    exp_err   = 1'b0;
    frame_pos = 0;
    #1;
    chk_outs("rst_async", 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    stream("post_rst", 5, 8'h70, -1);

    // One lane, FRAME_LEN=1: latency 1 and last tracks valid.
    for (int c = 0; c < 4; c++) begin
      din_valid1 = (c < 2);
      din1       = (c < 2) ? 8'(8'h10 + c) : 8'hA5;
      tick();
      chk("n1/valid", 64'(dout_valid1), 64'(c < 2));
      chk("n1/last",  64'(dout_last1),  64'(c < 2));
      chk("n1/dout",  64'(dout1),       64'((c == 0) ? 8'h10 : 8'h11));
      chk("n1/err",   64'(align_err1),  64'h0);
    end
    din_valid1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qrd_deskew.md
# qrd_deskew

Output-side realignment stage for the 5x5 QRD-RLS systolic array. Each array row emits its result one cycle after the row above it, so lane k of a column arrives k cycles after lane 0. This block removes that stagger and presents one parallel, aligned word per sample with a valid flag. It also tags frame boundaries and flags misaligned arrivals. It is the counterpart of the input-side skew delay lines.

## Interface
Parameters:
- N, 5, number of lanes (array rows).
- DATA_LENGTH, 8, bits per lane sample.
- FRAME_LEN, 5, aligned words per frame, used for `dout_last`; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- din  in  N*DATA_LENGTH  lane k in bits [k*DATA_LENGTH +: DATA_LENGTH]; lane k lags lane 0 by k cycles.
- din_valid  in  N  per-lane sample valid, same stagger as `din`.
- dout  out  N*DATA_LENGTH  aligned word, same lane packing as `din`.
- dout_valid  out  1  `dout` holds a fully aligned sample this cycle.
- dout_last  out  1  qualifies `dout_valid`; marks the last word of a frame.
- align_err  out  1  sticky; set on the first misaligned beat, cleared only by reset.

## Operation
- Lane k data and valid pass through a delay of N-1-k register stages, then a common output register.
  - Lane N-1 has zero added stages.
  - Lane 0 has N-1 added stages.
- Aligned valid vector `v` is the N delayed valids sampled at the output-register input.
  - All bits set: load `dout` from the aligned data, assert `dout_valid`, advance the frame counter.
  - All bits clear: `dout_valid`=0, `dout` holds its previous value, counter holds.
  - Mixed (misaligned): `dout_valid`=0, `dout` holds, counter holds, `align_err` set.
- Frame counter:
  - Width is $clog2(FRAME_LEN), minimum 1.
  - Counts 0..FRAME_LEN-1 on valid beats.
  - `dout_last`=1 on the beat loaded while the counter equals FRAME_LEN-1; the counter then wraps to 0.
  - FRAME_LEN=1: every valid beat is last.
- Data on lanes whose valid is low is don't-care. It is shifted but never exposed, because `dout` loads only on all-valid beats.
- No backpressure. The consumer must accept every `dout_valid` beat.

## Timing
- Latency: lane 0 input to `dout` is N cycles (5 at default). Lane k input to `dout` is N-k cycles. All lanes of one sample leave on the same edge.
- Throughput: one aligned word per cycle, back-to-back frames with no gap.
- Reset (rst_n low, async), all cleared immediately:
  - every delay stage data and valid set to 0;
  - `dout`=0, `dout_valid`=0, `dout_last`=0, `align_err`=0;
  - frame counter set to 0.
- Reset mid-operation: in-flight samples are dropped. After release, the first `dout_valid` is no earlier than N cycles after lane 0 valid. The counter restarts at 0.
- Removal of reset is synchronised by the integrating design; this block does not synchronise it.
- `align_err` asserts on the same edge as the would-be output beat and stays high.

## Structure
- Shared package `qrd_pkg`:
  - N and DATA_LENGTH defaults;
  - lane-slice index helper;
  - frame counter width function.
  - The input skew block and the array use the same package.
- Sub-module `lane_delay`, instantiated once per lane:
  - parameters DEPTH and WIDTH, DEPTH ≥ 0;
  - with async active-low reset;
  - carries {valid, data};
  - DEPTH=0 is a wire-through.
- Top level contains only the lane generate loop, the output register, the misalignment check and the frame counter.

## Test plan
- Ideal stagger, N=5, DL=8: lane k gets value 8'h10+k with valid high at cycle t0+k → at t0+5, `dout`=40'h14_13_12_11_10 and `dout_valid`=1 for exactly one cycle.
- Continuous frames: 10 staggered samples back-to-back, FRAME_LEN=5 → `dout_valid` high for 10 consecutive cycles; `dout_last` high on beats 5 and 10 only.
- Misalignment: lane 3 valid one cycle late → `dout_valid` stays 0 for that sample, `align_err` rises and stays 1, frame counter unchanged.
- Idle hold: after a valid beat, drive random `din` with all valids low for 20 cycles → `dout` unchanged and `dout_valid`=0 throughout.
- Reset mid-frame: assert rst_n low asynchronously, between clock edges, after 3 of 5 beats → all outputs 0 immediately. The next clean frame starts the counter at 0, so `dout_last` falls on its 5th beat.
- Parameter sweep: N=1 (latency 1, no stagger) and FRAME_LEN=1 (`dout_last` equals `dout_valid`) → both pass the ideal-stagger check.
